// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 responder.
package tm1638_pkg;

  // Command class, taken from bits 7:6 of the first byte after STB falls.
  typedef enum logic [1:0] {
    CMD_NONE    = 2'b00,
    CMD_DATA    = 2'b01,
    CMD_DISPLAY = 2'b10,
    CMD_ADDR    = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_IGNORE = 3'd4
  } state_e;

  localparam int READ_BIT    = 1;  // data command: 1 = key read
  localparam int FIXED_BIT   = 2;  // data command: 1 = fixed address
  localparam int DISP_ON_BIT = 3;  // display control: display enable
  localparam int RAM_DEPTH   = 16;

endpackage

// File: rtl/tm1638_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses.
// q is the synchronized level aligned with the rise/fall pulses, so a data
// line sampled through q lines up with an edge event on a sibling line.
module tm1638_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;

  // Shift the pin through the chain and compare against the previous level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side model: decodes STB/CLK/DIO commands, holds the display
// RAM and returns key-scan data on reads.
// Optional macro TM1638_RESP_KEY_SNAPSHOT_EN: when defined the whole key word
// is captured at read-command completion; otherwise each byte is reloaded
// from live i_Keys at its first falling edge.
module tm1638_responder import tm1638_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int READ_WIDTH  = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_SPI_Stb,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_Dio,
  output logic                  o_SPI_Dio,
  output logic                  o_SPI_Dio_Oe,
  input  logic [READ_WIDTH-1:0] i_Keys,
  input  logic [3:0]            i_Ram_Addr,
  output logic [7:0]            o_Ram_Data,
  output logic                  o_Display_On,
  output logic [2:0]            o_Brightness,
  output logic [2:0]            o_Diag_State
);
  localparam int CW = $clog2(READ_WIDTH + 1);

  logic stb_lvl, stb_rise, stb_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic dio_lvl, dio_rise, dio_fall;
  logic unused_sync;
  assign unused_sync = &{1'b0, stb_lvl, clk_lvl, dio_rise, dio_fall};

  // STB resets low so a strobe already low at reset release is not taken
  // as a new command; the FSM only starts after STB has been seen high.
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stb (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_Stb), .q(stb_lvl), .rise(stb_rise), .fall(stb_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_Clk), .q(clk_lvl), .rise(clk_rise), .fall(clk_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_Dio), .q(dio_lvl), .rise(dio_rise), .fall(dio_fall));

  state_e                        state_q, state_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [7:0]                    sr_q, sr_d;
  logic [3:0]                    ptr_q, ptr_d;
  logic                          fixed_q, fixed_d;
  logic [CW-1:0]                 rcnt_q, rcnt_d, fcnt_q, fcnt_d;
  logic [READ_WIDTH-1:0]         tx_q, tx_d;
  logic                          dio_q, dio_d, oe_q, oe_d, on_q, on_d;
  logic [2:0]                    br_q, br_d;
  logic [RAM_DEPTH-1:0][7:0]     ram_q, ram_d;
  logic [7:0]                    rdat_q, rdat_d;
  logic [7:0]                    byte_in;
  logic [READ_WIDTH-1:0]         cur;

  // Command decode, byte assembly, RAM writes and key-data shifting.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; sr_d = sr_q; ptr_d = ptr_q;
    fixed_d = fixed_q; rcnt_d = rcnt_q; fcnt_d = fcnt_q; tx_d = tx_q;
    dio_d = dio_q; oe_d = oe_q; on_d = on_q; br_d = br_q; ram_d = ram_q;
    byte_in = {dio_lvl, sr_q[7:1]};
    cur     = tx_q;
    rdat_d  = ram_q[i_Ram_Addr];
    if (stb_rise) begin
      // STB rise wins over any concurrent clock edge; partial byte dropped.
      state_d = ST_IDLE; cnt_d = 3'd0; oe_d = 1'b0; dio_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (stb_fall) begin state_d = ST_CMD; cnt_d = 3'd0; end
        ST_CMD: if (clk_rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_IGNORE;
            case (byte_in[7:6])
              CMD_DATA:
                if (byte_in[READ_BIT]) begin
                  state_d = ST_READ; tx_d = i_Keys;
                  rcnt_d = '0; fcnt_d = '0;
                end else fixed_d = byte_in[FIXED_BIT];
              CMD_DISPLAY: begin on_d = byte_in[DISP_ON_BIT]; br_d = byte_in[2:0]; end
              CMD_ADDR: begin state_d = ST_WRITE; ptr_d = byte_in[3:0]; end
              default: ;
            endcase
          end
        end
        ST_WRITE: if (clk_rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ram_d[ptr_q] = byte_in;
            if (!fixed_q) ptr_d = ptr_q + 4'd1;
          end
        end
        ST_READ: if (clk_rise) begin
          rcnt_d = rcnt_q + CW'(1);
          if (rcnt_q == CW'(READ_WIDTH - 1)) begin
            state_d = ST_IGNORE; oe_d = 1'b0; dio_d = 1'b0;
          end
        end else if (clk_fall) begin
`ifndef TM1638_RESP_KEY_SNAPSHOT_EN
          if (fcnt_q[2:0] == 3'd0) cur = i_Keys >> fcnt_q;
`endif
          dio_d  = cur[0];
          tx_d   = cur >> 1;
          oe_d   = 1'b1;
          fcnt_d = fcnt_q + CW'(1);
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE; cnt_q <= '0; sr_q <= '0; ptr_q <= '0; fixed_q <= 1'b0;
      rcnt_q <= '0; fcnt_q <= '0; tx_q <= '0; dio_q <= 1'b0; oe_q <= 1'b0;
      on_q <= 1'b0; br_q <= '0; ram_q <= '0; rdat_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; sr_q <= sr_d; ptr_q <= ptr_d; fixed_q <= fixed_d;
      rcnt_q <= rcnt_d; fcnt_q <= fcnt_d; tx_q <= tx_d; dio_q <= dio_d; oe_q <= oe_d;
      on_q <= on_d; br_q <= br_d; ram_q <= ram_d; rdat_q <= rdat_d;
    end
  end

  assign o_SPI_Dio    = dio_q;
  assign o_SPI_Dio_Oe = oe_q;
  assign o_Ram_Data   = rdat_q;
  assign o_Display_On = on_q;
  assign o_Brightness = br_q;
  assign o_Diag_State = state_q;
endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder with a transaction-level model.
module tb_tm1638_responder;
  localparam int NS = 2, RW = 32, H = 6;

  logic          i_Clk = 1'b0, i_Rst = 1'b1;
  logic          i_SPI_Stb = 1'b1, i_SPI_Clk = 1'b1, i_SPI_Dio = 1'b0;
  logic          o_SPI_Dio, o_SPI_Dio_Oe, o_Display_On;
  logic [RW-1:0] i_Keys = '0;
  logic [3:0]    i_Ram_Addr = '0;
  logic [7:0]    o_Ram_Data;
  logic [2:0]    o_Brightness, o_Diag_State;

  int errors = 0, checks = 0;

  // Reference model state: what the device should hold after whole transactions.
  logic [7:0] m_ram [16];
  logic       m_fixed, m_on;
  logic [2:0] m_br;
  logic [7:0] pay [8];

  tm1638_responder #(.SYNC_STAGES(NS), .READ_WIDTH(RW)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_Stb(i_SPI_Stb), .i_SPI_Clk(i_SPI_Clk),
    .i_SPI_Dio(i_SPI_Dio), .o_SPI_Dio(o_SPI_Dio), .o_SPI_Dio_Oe(o_SPI_Dio_Oe),
    .i_Keys(i_Keys), .i_Ram_Addr(i_Ram_Addr), .o_Ram_Data(o_Ram_Data),
    .o_Display_On(o_Display_On), .o_Brightness(o_Brightness), .o_Diag_State(o_Diag_State));

  always #5 i_Clk = ~i_Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed = 1'b0; m_on = 1'b0; m_br = 3'd0;
  endtask

  // Apply one complete transaction (command + n payload bytes) to the model.
  task automatic model_txn(input logic [7:0] cmd, input int n);
    case (cmd[7:6])
      2'b01: if (!cmd[1]) m_fixed = cmd[2];
      2'b10: begin m_on = cmd[3]; m_br = cmd[2:0]; end
      2'b11: for (int j = 0; j < n; j++) m_ram[(cmd[3:0] + (m_fixed ? 0 : j)) % 16] = pay[j];
      default: ;
    endcase
  endtask

  task automatic xfer_begin();
    i_SPI_Stb = 1'b0; wait_clks(H);
  endtask

  task automatic xfer_end();
    wait_clks(H); i_SPI_Stb = 1'b1; wait_clks(2 * H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i_SPI_Clk = 1'b0; i_SPI_Dio = b[i]; wait_clks(H);
      i_SPI_Clk = 1'b1; wait_clks(H);
    end
  endtask

  task automatic send_txn(input logic [7:0] cmd, input int n);
    xfer_begin();
    send_bits(cmd, 8);
    for (int j = 0; j < n; j++) send_bits(pay[j], 8);
    xfer_end();
    model_txn(cmd, n);
  endtask

  // Clock out n bits; sample DIO as the rising edge is driven. Optionally
  // change i_Keys right after rising edge index chg.
  task automatic read_bits(input int n, input int chg, input logic [31:0] nk,
                           output logic [31:0] w, output int oebad);
    w = '0; oebad = 0;
    for (int i = 0; i < n; i++) begin
      i_SPI_Clk = 1'b0; wait_clks(H);
      i_SPI_Clk = 1'b1;
      w[i] = o_SPI_Dio;
      if (o_SPI_Dio_Oe !== 1'b1) oebad++;
      if (i == chg) i_Keys = nk;
      wait_clks(H);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 16; a++) begin
      i_Ram_Addr = a[3:0];
      wait_clks(1);
      checks++;
      if (o_Ram_Data !== m_ram[a]) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %02h expected %02h", tag, a, o_Ram_Data, m_ram[a]);
      end
    end
  endtask

  task automatic do_reset();
    i_Rst = 1'b1; wait_clks(3); i_Rst = 1'b0; wait_clks(4);
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_SPI_Dio_Oe, o_SPI_Dio, o_Display_On, o_Brightness, o_Diag_State} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got oe=%b dio=%b on=%b br=%0d st=%0d expected all 0",
               o_SPI_Dio_Oe, o_SPI_Dio, o_Display_On, o_Brightness, o_Diag_State);
    end
    check_ram("reset");
  endtask

  task automatic test_write_auto();
    send_txn(8'h40, 0);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_txn(8'hC0, 3);
    for (int a = 0; a < 4; a++) begin
      i_Ram_Addr = a[3:0]; wait_clks(1);
      checks++;
      if (o_Ram_Data !== ((a < 3) ? 8'(a + 1) : 8'h00)) begin
        errors++;
        $display("FAIL write_auto ram[%0d]: got %02h expected %02h", a, o_Ram_Data,
                 (a < 3) ? 8'(a + 1) : 8'h00);
      end
    end
  endtask

  task automatic test_fixed_wrap();
    send_txn(8'h44, 0);
    pay[0] = 8'hAA; pay[1] = 8'h55;
    send_txn(8'hCF, 2);
    i_Ram_Addr = 4'hF; wait_clks(1);
    checks++;
    if (o_Ram_Data !== 8'h55) begin
      errors++; $display("FAIL fixed ram[15]: got %02h expected 55", o_Ram_Data);
    end
    i_Ram_Addr = 4'h0; wait_clks(1);
    checks++;
    if (o_Ram_Data !== 8'h01) begin
      errors++; $display("FAIL fixed ram[0]_untouched: got %02h expected 01", o_Ram_Data);
    end
    send_txn(8'h40, 0);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_txn(8'hCF, 2);
    check_ram("wrap");
  endtask

  task automatic test_display();
    xfer_begin();
    send_bits(8'h8A, 8);
    checks++;
    if (o_Display_On !== 1'b1 || o_Brightness !== 3'd2) begin
      errors++;
      $display("FAIL display: got on=%b br=%0d expected on=1 br=2", o_Display_On, o_Brightness);
    end
    xfer_end();
    model_txn(8'h8A, 0);
  endtask

  task automatic test_read();
    logic [31:0] w; int ob;
    i_Keys = 32'hDEADBEEF;
    xfer_begin();
    send_bits(8'h42, 8);
    read_bits(32, -1, '0, w, ob);
    checks++;
    if (w !== 32'hDEADBEEF || ob != 0) begin
      errors++; $display("FAIL read_word: got %08h (oe low %0d bits) expected deadbeef", w, ob);
    end
    checks++;
    if (o_SPI_Dio_Oe !== 1'b0) begin
      errors++; $display("FAIL read_oe_drop: got oe=%b expected 0", o_SPI_Dio_Oe);
    end
    xfer_end();
  endtask

  task automatic test_keys_change();
    logic [31:0] w, exp_w; int ob;
    i_Keys = 32'h12345678;
`ifdef TM1638_RESP_KEY_SNAPSHOT_EN
    exp_w = 32'h12345678;
`else
    exp_w = 32'hCAFE5678;   // bytes 2,3 start after the change
`endif
    xfer_begin();
    send_bits(8'h42, 8);
    read_bits(32, 11, 32'hCAFEF00D, w, ob);
    checks++;
    if (w !== exp_w || ob != 0) begin
      errors++; $display("FAIL keys_change: got %08h (oe low %0d) expected %08h", w, ob, exp_w);
    end
    xfer_end();
  endtask

  task automatic test_abort();
    logic [31:0] w; int ob;
    // Partial byte after an address command must not reach RAM.
    xfer_begin();
    send_bits(8'hC5, 8);
    send_bits(8'hFF, 4);
    i_SPI_Stb = 1'b1; wait_clks(NS + 2);
    checks++;
    if (o_Diag_State !== 3'd0) begin
      errors++; $display("FAIL abort_write_state: got %0d expected 0", o_Diag_State);
    end
    wait_clks(2 * H);
    check_ram("abort_write");
    // STB rise in the middle of a read drops OE promptly.
    i_Keys = 32'hFFFFFFFF;
    xfer_begin();
    send_bits(8'h42, 8);
    read_bits(5, -1, '0, w, ob);
    checks++;
    if (o_SPI_Dio_Oe !== 1'b1) begin
      errors++; $display("FAIL abort_read_oe_on: got %b expected 1", o_SPI_Dio_Oe);
    end
    i_SPI_Stb = 1'b1; wait_clks(NS + 2);
    checks++;
    if (o_SPI_Dio_Oe !== 1'b0 || o_Diag_State !== 3'd0) begin
      errors++;
      $display("FAIL abort_read: got oe=%b st=%0d expected oe=0 st=0", o_SPI_Dio_Oe, o_Diag_State);
    end
    wait_clks(2 * H);
  endtask

  task automatic test_random();
    logic [31:0] w, k; int ob, kind, n;
    logic [7:0] cmd;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          cmd = 8'h40 | 8'($urandom_range(0, 1) << 2);
          send_txn(cmd, 0);
          n = $urandom_range(1, 5);
          for (int j = 0; j < n; j++) pay[j] = 8'($urandom);
          send_txn(8'hC0 | 8'($urandom_range(0, 15)), n);
        end
        1: begin
          pay[0] = 8'($urandom);
          send_txn({2'b10, 6'($urandom)}, 1);
          checks++;
          if (o_Display_On !== m_on || o_Brightness !== m_br) begin
            errors++;
            $display("FAIL rand_display: got on=%b br=%0d expected on=%b br=%0d",
                     o_Display_On, o_Brightness, m_on, m_br);
          end
        end
        2: begin
          k = $urandom; i_Keys = k;
          xfer_begin();
          send_bits(8'h42, 8);
          read_bits(32, -1, '0, w, ob);
          xfer_end();
          checks++;
          if (w !== k || ob != 0) begin
            errors++; $display("FAIL rand_read: got %08h (oe low %0d) expected %08h", w, ob, k);
          end
        end
        default: begin
          pay[0] = 8'($urandom);
          send_txn({2'b00, 6'($urandom)}, 1);
        end
      endcase
    end
    check_ram("random");
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] w; int ob;
    i_Keys = 32'hFFFFFFFF;
    xfer_begin();
    send_bits(8'h42, 8);
    read_bits(6, -1, '0, w, ob);
    i_Rst = 1'b1; #1;
    checks++;
    if (o_SPI_Dio_Oe !== 1'b0 || o_Diag_State !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_read: got oe=%b st=%0d expected oe=0 st=0", o_SPI_Dio_Oe, o_Diag_State);
    end
    wait_clks(3); i_Rst = 1'b0; model_reset();
    wait_clks(4);
    i_SPI_Clk = 1'b1; i_SPI_Stb = 1'b1; wait_clks(2 * H);
    pay[0] = 8'h77;
    send_txn(8'hC3, 1);
    check_ram("after_reset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_auto();
    test_fixed_wrap();
    test_display();
    test_read();
    test_keys_change();
    test_abort();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

Synthesizable TM1638 target model: the device end of the 3-wire STB/CLK/DIO link driven by the `spi` initiator. Oversamples the serial lines in the system clock domain, decodes data, address and display-control commands, holds the 16-byte display RAM, and returns 32 bits of key-scan data on read commands. Used as an on-FPGA loopback partner and as the DUT-side model in `spi` regressions.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on STB, CLK and DIO inputs (min 2).
- `READ_WIDTH`, 32: key-scan bits returned per read; multiple of 8.
- `i_Clk` in 1: system clock.
- `i_Rst` in 1: reset, asynchronous, active-high.
- `i_SPI_Stb` in 1: strobe, active low.
- `i_SPI_Clk` in 1: serial clock, idles high.
- `i_SPI_Dio` in 1: DIO input path.
- `o_SPI_Dio` out 1: DIO output value; top level ties a tristate buffer.
- `o_SPI_Dio_Oe` out 1: DIO drive enable.
- `i_Keys` in READ_WIDTH: key-scan data.
- `i_Ram_Addr` in 4: display RAM read address.
- `o_Ram_Data` out 8: `RAM[i_Ram_Addr]`, registered, 1-cycle latency.
- `o_Display_On` out 1: display-control bit 3.
- `o_Brightness` out 3: display-control bits 2:0.
- `o_Diag_State` out 3: current FSM state.

## Operation
- Bytes LSB first; bit sampled on each detected CLK rising edge while STB low.
- First byte after STB falls is the command; bits 7:6 decode:
  - 01 data command: bit 1 = read, bit 2 = fixed address. Write form updates the stored mode; read form enters READ.
  - 10 display control: updates `o_Display_On` and `o_Brightness` at the 8th rising edge.
  - 11 address: address pointer = bits 3:0; following bytes are written to RAM.
  - 00: ignored.
- FSM states:
  - IDLE: STB high. Enter CMD when STB falls.
  - CMD: shift in the command byte, then go to WRITE (address cmd), READ (read cmd), or IGNORE (all others).
  - WRITE: each completed byte writes `RAM[ptr]`. Pointer increments modulo 16 (15 wraps to 0) unless fixed mode.
  - READ: load shifter with `i_Keys` at command completion. On each detected CLK falling edge, drive the next bit (`i_Keys[0]` first) with OE high. After the READ_WIDTH-th rising edge, drop OE and go to IGNORE.
  - IGNORE: discard all clocks until STB rises.
- STB rising from any state returns to IDLE. A partial byte is discarded with no RAM write, and OE drops in the same cycle as the detection.
- Excess bytes after a display or data command are ignored. Bytes after an address command keep writing with wrap.
- Mode register reset value: auto-increment, write.

## Timing
- Reset values:
  - `o_SPI_Dio_Oe` = 0, `o_SPI_Dio` = 0.
  - `o_Display_On` = 0, `o_Brightness` = 0.
  - `o_Ram_Data` = 0, all RAM bytes 0.
  - `o_Diag_State` = IDLE, pointer 0.
- Reset may assert mid-transaction and takes effect immediately. After release, the block waits for STB high before accepting a new command.
- Edge detection latency: SYNC_STAGES+1 cycles from the pin to the internal event.
- Each CLK high and low phase must last ≥ SYNC_STAGES+2 `i_Clk` cycles.
- DIO output changes SYNC_STAGES+2 cycles after a pin falling edge. The initiator must sample on the rising edge.
- RAM write lands 1 cycle after the 8th rising edge of the byte. A same-address read port access in that cycle returns the old data.
- Simultaneous STB-rise and CLK-rise detection: STB wins, and the partial bit is dropped.

## Configuration
- `TM1638_RESP_KEY_SNAPSHOT_EN`
  - Defined: `i_Keys` is captured once at read-command completion. All READ_WIDTH bits come from that snapshot.
  - Undefined: the shifter reloads each byte from live `i_Keys[8k+7:8k]` at its first falling edge.

## Structure
- Shared package `tm1638_pkg`:
  - Command-type enum (DATA, DISPLAY, ADDR).
  - FSM state enum.
  - Bit-position constants for read, fixed-address and display-on bits.
  - `RAM_DEPTH` = 16.
- Sub-module `tm1638_sync_edge`: an N-stage synchronizer plus rise/fall pulse generator. Instantiated three times (STB, CLK, DIO).

## Test plan
- Write 0x40, then 0xC0 followed by 0x01, 0x02, 0x03 -> RAM[0..2] = 01, 02, 03; pointer stops at 3.
- Write 0x44 (fixed mode), then 0xCF followed by 0xAA, 0x55 -> RAM[15] = 0x55, RAM[0] untouched. In auto mode, 0xCF followed by 2 bytes -> RAM[15], RAM[0] written (wrap).
- Send display control 0x8A -> `o_Display_On` = 1, `o_Brightness` = 2 after the 8th rising edge.
- Set `i_Keys` = 0xDEADBEEF and send read 0x42 -> 32 bits on DIO LSB first reassemble to 0xDEADBEEF. OE is low after the 32nd rising edge.
- With snapshot enabled, change `i_Keys` mid-read -> the returned word equals the pre-change value.
- STB rises after 4 data bits, or reset asserts mid-read -> no RAM write, OE = 0 within SYNC_STAGES+2 cycles, state IDLE. The next command decodes normally.
